cpu_register_file: RTL and testbench
====================================

# cpu_register_file

General-purpose integer register file for the CPU datapath: 32 registers of 32 bits, two combinational read ports (A, B) and one clocked write port (D). Decode supplies the source register addresses; operands go to the ALU on bus_A/bus_B. Writeback drives bus_D/address_D with register_load. Register 0 is hardwired to zero.

## Interface
- DATA_WIDTH, 32, register and bus width
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH (32)
- clk  input  1  system clock; all writes on rising edge
- reset  input  1  one clock; reset is asynchronous and active-low; clears every register to 0
- register_load  input  1  write enable for port D
- address_A  input  ADDR_WIDTH  read address, port A
- address_B  input  ADDR_WIDTH  read address, port B
- address_D  input  ADDR_WIDTH  write address, port D
- bus_D  input  DATA_WIDTH  write data
- bus_A  output  DATA_WIDTH  contents of register[address_A]
- bus_B  output  DATA_WIDTH  contents of register[address_B]

## Operation
- Storage: 32 x 32-bit registers, x0..x31.
- Write: on rising clk with reset deasserted (high) and register_load=1, register[address_D] <= bus_D. With register_load=0 there is no state change.
- x0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 32'h0.
- Read: bus_A and bus_B are purely combinational decodes of the stored array.
  - Ports A and B are independent and may select the same or different registers.
- Unknown/undriven addresses or data are not masked. The implementation is not required to tolerate X on address_D while register_load=1.
- No internal bypass: a read of the register being written returns the old value until the write edge, then the new value.

## Timing
- Read latency: 0 cycles; bus_A/bus_B follow address and register changes combinationally.
- Write latency: 1 edge; value is visible on a read port immediately after the capturing rising edge.
- Reset assertion (reset=0):
  - Immediately, without waiting for clk, all registers become 0.
  - So bus_A = bus_B = 0 for every address.
- While reset=0:
  - Writes are ignored regardless of register_load.
  - Outputs stay 0.
- Reset release: the first write can occur on the first rising edge with reset=1.
- Reset mid-operation: an in-flight write at the same edge as reset assertion is lost; the register reads 0.
- Simultaneous read and write to the same address in one cycle: the read returns the pre-edge value before the edge and the post-edge value after it.

## Test plan
- Reset check: hold reset=0, then release. Sweep address_A/address_B over 0..31 -> bus_A = bus_B = 0 for all addresses.
- Write sweep:
  - Stimulus: register_load=1; on 32 consecutive edges drive address_D=i, bus_D=i for i=0..31.
  - Then sweep address_A=address_B=i.
  - Response: bus_A = bus_B = i for i=1..31; 0 for i=0.
- Enable gating: write 32'hDEAD_BEEF to x5, then drive register_load=0 with address_D=5, bus_D=32'h1234_5678 for 3 edges -> x5 still reads 32'hDEAD_BEEF.
- Dual port: after the write sweep, drive address_A=7 and address_B=31 -> bus_A=7, bus_B=31 in the same cycle.
- Read-during-write: x9=9; drive address_A=9, address_D=9, bus_D=32'hA5A5_A5A5, register_load=1 -> bus_A=9 before the edge, 32'hA5A5_A5A5 after it.
- Async reset mid-operation: with registers loaded, pull reset low between clock edges -> bus_A/bus_B go to 0 before the next edge. After release, all registers read 0 until rewritten.

Source files
------------

// File: rtl/cpu_register_file.sv
// 32 x 32-bit integer register file: two combinational read ports (A, B),
// one clocked write port (D), x0 hardwired to zero, async active-low clear.
module cpu_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  register_load,
  input  logic [ADDR_WIDTH-1:0] address_A,
  input  logic [ADDR_WIDTH-1:0] address_B,
  input  logic [ADDR_WIDTH-1:0] address_D,
  input  logic [DATA_WIDTH-1:0] bus_D,
  output logic [DATA_WIDTH-1:0] bus_A,
  output logic [DATA_WIDTH-1:0] bus_B
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  wr_en_c;

  // x0 is never written, so its storage stays at the reset value of zero
  assign wr_en_c = register_load && (address_D != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs_q[address_D] <= bus_D;
    end
  end

  // Explicit zero on address 0 keeps reads of x0 independent of storage
  assign bus_A = (address_A == '0) ? '0 : regs_q[address_A];
  assign bus_B = (address_B == '0) ? '0 : regs_q[address_B];

endmodule

// File: tb/tb_cpu_register_file.sv
// Self-checking bench for cpu_register_file: directed steps plus a random
// phase checked against an array-based reference model.
module tb_cpu_register_file;

  logic        clk;
  logic        reset;
  logic        register_load;
  logic [4:0]  address_A;
  logic [4:0]  address_B;
  logic [4:0]  address_D;
  logic [31:0] bus_D;
  logic [31:0] bus_A;
  logic [31:0] bus_B;

  int checks;
  int errors;
  logic [31:0] model [32];

  cpu_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .register_load (register_load),
    .address_A     (address_A),
    .address_B     (address_B),
    .address_D     (address_D),
    .bus_D         (bus_D),
    .bus_A         (bus_A),
    .bus_B         (bus_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference read: x0 reads zero, everything else is the stored word
  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  // One rising edge; apply the architectural write rule to the model
  task automatic edge_step();
    @(posedge clk);
    if (reset && register_load && address_D != 5'd0) model[address_D] = bus_D;
    @(negedge clk);
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 0; i < 32; i++) begin
      address_A = 5'(i);
      address_B = 5'(31 - i);
      #1;
      check({tag, "_A"}, bus_A, ref_rd(5'(i)));
      check({tag, "_B"}, bus_B, ref_rd(5'(31 - i)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b0;
    register_load = 1'b1;
    address_A = 5'd3;
    address_B = 5'd4;
    address_D = 5'd3;
    bus_D = 32'hFFFF_FFFF;

    // Held in reset: writes ignored, outputs zero
    repeat (3) edge_step();
    #1;
    check("in_reset_A", bus_A, 32'h0);
    check("in_reset_B", bus_B, 32'h0);
    register_load = 1'b0;
    reset = 1'b1;
    sweep_check("post_reset");

    // Write sweep i -> xi
    register_load = 1'b1;
    for (int i = 0; i < 32; i++) begin
      address_D = 5'(i);
      bus_D = 32'(i);
      edge_step();
    end
    register_load = 1'b0;
    for (int i = 0; i < 32; i++) begin
      address_A = 5'(i);
      address_B = 5'(i);
      #1;
      check("sweep_A", bus_A, (i == 0) ? 32'h0 : 32'(i));
      check("sweep_B", bus_B, (i == 0) ? 32'h0 : 32'(i));
    end

    // Dual port
    address_A = 5'd7;
    address_B = 5'd31;
    #1;
    check("dual_A", bus_A, 32'd7);
    check("dual_B", bus_B, 32'd31);

    // Enable gating
    register_load = 1'b1;
    address_D = 5'd5;
    bus_D = 32'hDEAD_BEEF;
    edge_step();
    register_load = 1'b0;
    bus_D = 32'h1234_5678;
    repeat (3) edge_step();
    address_A = 5'd5;
    #1;
    check("gate_x5", bus_A, 32'hDEAD_BEEF);

    // Write to x0 discarded
    register_load = 1'b1;
    address_D = 5'd0;
    bus_D = 32'hCAFE_F00D;
    edge_step();
    register_load = 1'b0;
    address_A = 5'd0;
    #1;
    check("x0_write", bus_A, 32'h0);

    // Read during write: old value before the edge, new value after
    address_A = 5'd9;
    address_D = 5'd9;
    bus_D = 32'hA5A5_A5A5;
    register_load = 1'b1;
    #1;
    check("rdw_before", bus_A, 32'd9);
    edge_step();
    register_load = 1'b0;
    #1;
    check("rdw_after", bus_A, 32'hA5A5_A5A5);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      register_load = 1'($urandom_range(0, 3) != 0);
      address_D = 5'($urandom_range(0, 31));
      bus_D = $urandom;
      address_A = 5'($urandom_range(0, 31));
      address_B = ($urandom_range(0, 3) == 0) ? address_A : 5'($urandom_range(0, 31));
      #1;
      check("rand_pre_A", bus_A, ref_rd(address_A));
      check("rand_pre_B", bus_B, ref_rd(address_B));
      edge_step();
      #1;
      check("rand_post_A", bus_A, ref_rd(address_A));
      check("rand_post_B", bus_B, ref_rd(address_B));
    end

    // Make sure two readable registers are nonzero before the async reset
    register_load = 1'b1;
    address_D = 5'd12;
    bus_D = 32'h0BAD_0001;
    edge_step();
    address_D = 5'd20;
    bus_D = 32'h0BAD_0002;
    edge_step();
    address_A = 5'd12;
    address_B = 5'd20;
    #1;
    check("pre_areset_A", bus_A, 32'h0BAD_0001);
    check("pre_areset_B", bus_B, 32'h0BAD_0002);

    // Async reset between edges, with a write pending that must be lost
    address_D = 5'd12;
    bus_D = 32'h7777_7777;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    check("areset_A", bus_A, 32'h0);
    check("areset_B", bus_B, 32'h0);
    edge_step();
    #1;
    check("areset_hold_A", bus_A, 32'h0);
    register_load = 1'b0;
    reset = 1'b1;
    sweep_check("post_areset");

    // First edge after release accepts a write
    register_load = 1'b1;
    address_D = 5'd1;
    bus_D = 32'h1357_9BDF;
    edge_step();
    register_load = 1'b0;
    address_A = 5'd1;
    #1;
    check("first_write", bus_A, 32'h1357_9BDF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
